cmd_executor: RTL and testbench
===============================

Name: cmd_executor

Overview:
- Consumer end of the fetch/execute handshake. Accepts the 3-word command window and execute flag from the fetcher.
- Decodes and executes the command against an internal register file.
- Returns a one-cycle ready pulse with the executed command size, or with a jump flag and a relative offset, so the fetcher can advance its instruction pointer.
- Sits between the fetcher and the rest of the core; owns all architectural register state.

Parameters:
- WORD_SIZE_, 32, data word width in bits.
- ADDR_SIZE_, 32, code address and offset width in bits (word-addressed).
- REG_NUM_, 8, number of general registers (power of two, max 8).

Ports:
- CLK_  in  1  clock, all logic on posedge.
- RST_N_  in  1  synchronous, active-low reset.
- CMD_ARGS_  in  3*WORD_SIZE_  command window. word0=[W-1:0], word1=[2W-1:W], word2=[3W-1:2W].
- EXEC_FL_  in  1  window valid; execute request from the fetcher.
- READY_FL_  out  1  one-cycle pulse: command retired, fetcher may advance.
- PREV_CMD_SIZE_  out  2  size in words (1..3) of the retired command.
- JMP_FL_  out  1  with READY_FL_: apply the offset instead of the size.
- NEW_EXEC_ADDR_OFFSET_  out  ADDR_SIZE_  signed offset relative to the retired command's address.
- HALT_FL_  out  1  sticky: HLT executed or illegal opcode.
- ERR_FL_  out  1  sticky: illegal opcode.
- DBG_REG_IDX_  in  3  debug register select.
- DBG_REG_VAL_  out  WORD_SIZE_  combinational read of register DBG_REG_IDX_.

Behaviour:
- Reset (RST_N_=0 at posedge): every output register is 0, all registers are 0, state is IDLE. Reset overrides any state, including mid-MUL and mid-ACK; a partial result is never written.
- word0 encoding: opcode [7:0], rd [10:8], rs1 [14:12], rs2 [18:16]. Indices are taken modulo REG_NUM_.
- Opcodes (mnemonic, size, effect):
  - 0x00 NOP, 1: no effect.
  - 0x01 LDI, 2: rd=word1.
  - 0x02 ADD, 1: rd=rs1+rs2.
  - 0x03 SUB, 1: rd=rs1-rs2.
  - 0x04 MUL, 1: rd=low W bits of rs1*rs2.
  - 0x05 JMP, 2: offset=word1.
  - 0x06 JZ, 2: if rs1==0, offset=word1; else fall through.
  - 0x07 CMPJ, 3: offset = word1 if rs1==rs2, otherwise word2; always jumps.
  - 0xFF HLT, 1: halt.
- Arithmetic wraps modulo 2^W; no flags. Offsets are truncated or sign-extended from word1/word2 to ADDR_SIZE_. Operand reads use register values before this command's write.
- FSM states:
  - IDLE: if EXEC_FL_=1, latch CMD_ARGS_ and decode.
    - Single-cycle op: write rd, drive size/jump outputs, set READY_FL_<=1, go to ACK.
    - MUL: go to MUL.
    - HLT: set HALT_FL_, go to HALT; READY_FL_ is never asserted.
    - Illegal opcode: set ERR_FL_ and HALT_FL_, go to HALT.
  - MUL: iterative shift-add, one multiplier bit per cycle, WORD_SIZE_ cycles. Then write rd, set READY_FL_<=1, go to ACK.
  - ACK: READY_FL_<=0 and go to IDLE. The fetcher drops EXEC_FL_ on this same edge, so IDLE never re-executes a stale command.
  - HALT: absorbing until reset; EXEC_FL_ is ignored.
- Latency from the first edge sampling EXEC_FL_=1 to READY_FL_ high: 1 cycle for single-cycle ops, WORD_SIZE_+1 for MUL. Throughput is one single-cycle command per 3 clocks.
- Retire outputs: PREV_CMD_SIZE_, JMP_FL_ and NEW_EXEC_ADDR_OFFSET_ are registered, valid while READY_FL_=1 and held until the next retire.
  - JMP_FL_=0 implies offset=0.
  - PREV_CMD_SIZE_ always carries the true command size, including on jumps.
- EXEC_FL_ going low while in MUL is ignored; the command completes.

Decomposition:
- Shared package cmd_isa_pkg: opcode constants, field bit positions, command-size constants, FSM state encoding. The same package is used by the assembler/CODE.txt generator and the benches.
- One sub-module, seq_multiplier: start/busy/done plus a W-bit low-product result, WORD_SIZE_-cycle latency.
- The register file stays inline.

Test Plan:
- Reset then LDI r1,5 (word1=5) with EXEC_FL_ held high: READY_FL_ pulses 1 cycle later; PREV_CMD_SIZE_=2, JMP_FL_=0; DBG r1=5.
- r1=7, r2=9, then ADD r3,r1,r2 and SUB r4,r1,r2: r3=16 and r4=0xFFFFFFFE; each command asserts READY_FL_ for exactly one cycle.
- r1=0x10000, r2=0x10001, then MUL r5,r1,r2: READY_FL_ after 33 cycles; r5=0x00010000 (wrapped).
- JZ r0,-4 with r0=0: JMP_FL_=1, offset=0xFFFFFFFC, size=2. Same command with r0=1: JMP_FL_=0, offset=0.
- CMPJ r1,r2 with word1=8, word2=12: r1==r2 gives offset 8; r1!=r2 gives offset 12; size=3 in both cases.
- Opcode 0x42: ERR_FL_=1, HALT_FL_=1, no further READY_FL_. Separately, assert RST_N_=0 mid-MUL: outputs and registers return to 0, FSM goes to IDLE, rd is not written.

Source files
------------

// File: rtl/cmd_isa_pkg.sv
// Shared ISA definitions for the command executor, assembler and benches.
// Holds opcode values, word0 field positions, command sizes, the executor
// FSM state encoding and a size-lookup helper.
package cmd_isa_pkg;

    // Opcodes (word0[7:0])
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_MUL  = 8'h04;
    localparam logic [7:0] OP_JMP  = 8'h05;
    localparam logic [7:0] OP_JZ   = 8'h06;
    localparam logic [7:0] OP_CMPJ = 8'h07;
    localparam logic [7:0] OP_HLT  = 8'hFF;

    // word0 field positions
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_W   = 8;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_LSB = 12;
    localparam int unsigned RS2_LSB = 16;
    localparam int unsigned IDX_W   = 3;

    // Command sizes in words
    localparam logic [1:0] SZ_1 = 2'd1;
    localparam logic [1:0] SZ_2 = 2'd2;
    localparam logic [1:0] SZ_3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACK  = 2'd2,
        ST_HALT = 2'd3
    } exec_state_e;

    // Size of a legal command; illegal opcodes report 1 (never retired).
    function automatic logic [1:0] cmd_size(input logic [7:0] opc);
        case (opc)
            OP_LDI, OP_JMP, OP_JZ: cmd_size = SZ_2;
            OP_CMPJ:               cmd_size = SZ_3;
            default:               cmd_size = SZ_1;
        endcase
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a_i*b_i.
// The first partial product is taken on the start edge, so done_o pulses
// WIDTH cycles after the start edge and result_o is valid from then on.
// Ports: clk_i/rst_ni (sync, active-low), start_i, a_i, b_i,
//        busy_o, done_o (1-cycle pulse), result_o.
module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state: load with first step on start, then one bit per cycle
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start_i) begin
            acc_d    = b_i[0] ? a_i : '0;
            mcand_d  = a_i << 1;
            mplier_d = b_i >> 1;
            cnt_d    = CNT_W'(WIDTH - 1);
            busy_d   = (WIDTH > 1);
            done_d   = (WIDTH == 1);
        end else if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = acc_q;

endmodule

// File: rtl/cmd_executor.sv
// Consumer end of the fetch/execute handshake: decodes the 3-word command
// window, executes it against the internal register file and returns a
// one-cycle READY_FL_ pulse with the retired size or a jump offset.
// Ports: CLK_, RST_N_ (sync, active-low), CMD_ARGS_ (word0..word2), EXEC_FL_,
//        READY_FL_, PREV_CMD_SIZE_, JMP_FL_, NEW_EXEC_ADDR_OFFSET_,
//        HALT_FL_/ERR_FL_ (sticky), DBG_REG_IDX_/DBG_REG_VAL_ (comb read).
module cmd_executor
    import cmd_isa_pkg::*;
#(
    parameter int unsigned WORD_SIZE_ = 32,
    parameter int unsigned ADDR_SIZE_ = 32,
    parameter int unsigned REG_NUM_   = 8
) (
    input  logic                    CLK_,
    input  logic                    RST_N_,
    input  logic [3*WORD_SIZE_-1:0] CMD_ARGS_,
    input  logic                    EXEC_FL_,
    output logic                    READY_FL_,
    output logic [1:0]              PREV_CMD_SIZE_,
    output logic                    JMP_FL_,
    output logic [ADDR_SIZE_-1:0]   NEW_EXEC_ADDR_OFFSET_,
    output logic                    HALT_FL_,
    output logic                    ERR_FL_,
    input  logic [2:0]              DBG_REG_IDX_,
    output logic [WORD_SIZE_-1:0]   DBG_REG_VAL_
);

    localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(REG_NUM_ - 1);

    exec_state_e state_q, state_d;

    logic                  ready_q, ready_d;
    logic [1:0]            size_q, size_d;
    logic                  jmp_q, jmp_d;
    logic [ADDR_SIZE_-1:0] off_q, off_d;
    logic                  halt_q, halt_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      mul_rd_q, mul_rd_d;

    logic [WORD_SIZE_-1:0] regs_q [REG_NUM_];

    // Decoded fields of the current window
    logic [WORD_SIZE_-1:0] word0_c, word1_c, word2_c;
    logic [7:0]            opcode_c;
    logic [IDX_W-1:0]      rd_c, rs1_c, rs2_c;
    logic [WORD_SIZE_-1:0] rs1_val_c, rs2_val_c;
    logic [ADDR_SIZE_-1:0] off1_c, off2_c;

    logic                  wr_en_c;
    logic [IDX_W-1:0]      wr_idx_c;
    logic [WORD_SIZE_-1:0] wr_data_c;
    logic                  retire_c;

    logic                  mul_start_c;
    logic                  mul_busy;
    logic                  mul_done;
    logic [WORD_SIZE_-1:0] mul_result;

    assign word0_c   = CMD_ARGS_[WORD_SIZE_-1:0];
    assign word1_c   = CMD_ARGS_[2*WORD_SIZE_-1:WORD_SIZE_];
    assign word2_c   = CMD_ARGS_[3*WORD_SIZE_-1:2*WORD_SIZE_];
    assign opcode_c  = word0_c[OPC_LSB +: OPC_W];
    assign rd_c      = word0_c[RD_LSB  +: IDX_W] & IDX_MASK;
    assign rs1_c     = word0_c[RS1_LSB +: IDX_W] & IDX_MASK;
    assign rs2_c     = word0_c[RS2_LSB +: IDX_W] & IDX_MASK;
    assign rs1_val_c = regs_q[rs1_c];
    assign rs2_val_c = regs_q[rs2_c];

    // Offsets are sign-extended (or truncated) to the address width
    assign off1_c = ADDR_SIZE_'(signed'(word1_c));
    assign off2_c = ADDR_SIZE_'(signed'(word2_c));

    // Reserved word0 bits and the busy flag carry no information here
    logic unused_c;
    assign unused_c = ^{word0_c[WORD_SIZE_-1:19], word0_c[15], word0_c[11], mul_busy};

    seq_multiplier #(
        .WIDTH(WORD_SIZE_)
    ) u_mul (
        .clk_i   (CLK_),
        .rst_ni  (RST_N_),
        .start_i (mul_start_c),
        .a_i     (rs1_val_c),
        .b_i     (rs2_val_c),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .result_o(mul_result)
    );

    // Next-state, register-file write and retire outputs
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        size_d      = size_q;
        jmp_d       = jmp_q;
        off_d       = off_q;
        halt_d      = halt_q;
        err_d       = err_q;
        mul_rd_d    = mul_rd_q;
        wr_en_c     = 1'b0;
        wr_idx_c    = rd_c;
        wr_data_c   = '0;
        retire_c    = 1'b0;
        mul_start_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (EXEC_FL_) begin
                    size_d = cmd_size(opcode_c);
                    jmp_d  = 1'b0;
                    off_d  = '0;
                    case (opcode_c)
                        OP_NOP: retire_c = 1'b1;
                        OP_LDI: begin
                            wr_en_c   = 1'b1;
                            wr_data_c = word1_c;
                            retire_c  = 1'b1;
                        end
                        OP_ADD: begin
                            wr_en_c   = 1'b1;
                            wr_data_c = rs1_val_c + rs2_val_c;
                            retire_c  = 1'b1;
                        end
                        OP_SUB: begin
                            wr_en_c   = 1'b1;
                            wr_data_c = rs1_val_c - rs2_val_c;
                            retire_c  = 1'b1;
                        end
                        OP_JMP: begin
                            jmp_d    = 1'b1;
                            off_d    = off1_c;
                            retire_c = 1'b1;
                        end
                        OP_JZ: begin
                            if (rs1_val_c == '0) begin
                                jmp_d = 1'b1;
                                off_d = off1_c;
                            end
                            retire_c = 1'b1;
                        end
                        OP_CMPJ: begin
                            jmp_d    = 1'b1;
                            off_d    = (rs1_val_c == rs2_val_c) ? off1_c : off2_c;
                            retire_c = 1'b1;
                        end
                        OP_MUL: begin
                            // Retire outputs keep the previous command until MUL finishes
                            size_d      = size_q;
                            jmp_d       = jmp_q;
                            off_d       = off_q;
                            mul_start_c = 1'b1;
                            mul_rd_d    = rd_c;
                            state_d     = ST_MUL;
                        end
                        OP_HLT: begin
                            size_d  = size_q;
                            jmp_d   = jmp_q;
                            off_d   = off_q;
                            halt_d  = 1'b1;
                            state_d = ST_HALT;
                        end
                        default: begin
                            size_d  = size_q;
                            jmp_d   = jmp_q;
                            off_d   = off_q;
                            err_d   = 1'b1;
                            halt_d  = 1'b1;
                            state_d = ST_HALT;
                        end
                    endcase
                    if (retire_c) begin
                        ready_d = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    wr_en_c   = 1'b1;
                    wr_idx_c  = mul_rd_q;
                    wr_data_c = mul_result;
                    size_d    = SZ_1;
                    jmp_d     = 1'b0;
                    off_d     = '0;
                    ready_d   = 1'b1;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_) begin
        if (!RST_N_) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            size_q   <= '0;
            jmp_q    <= 1'b0;
            off_q    <= '0;
            halt_q   <= 1'b0;
            err_q    <= 1'b0;
            mul_rd_q <= '0;
            for (int i = 0; i < REG_NUM_; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            size_q   <= size_d;
            jmp_q    <= jmp_d;
            off_q    <= off_d;
            halt_q   <= halt_d;
            err_q    <= err_d;
            mul_rd_q <= mul_rd_d;
            if (wr_en_c) begin
                regs_q[wr_idx_c] <= wr_data_c;
            end
        end
    end

    assign READY_FL_             = ready_q;
    assign PREV_CMD_SIZE_        = size_q;
    assign JMP_FL_               = jmp_q;
    assign NEW_EXEC_ADDR_OFFSET_ = off_q;
    assign HALT_FL_              = halt_q;
    assign ERR_FL_               = err_q;
    assign DBG_REG_VAL_          = regs_q[DBG_REG_IDX_ & IDX_MASK];

endmodule

// File: tb/tb_cmd_executor.sv
// Directed bench for cmd_executor: a table of single commands with expected
// latency, retire outputs and one register value, followed by hand-written
// sequences for EXEC drop during MUL, reset mid-MUL/mid-ACK, illegal opcode
// and HLT.
module tb_cmd_executor;
    import cmd_isa_pkg::*;

    logic        CLK_;
    logic        RST_N_;
    logic [95:0] CMD_ARGS_;
    logic        EXEC_FL_;
    logic        READY_FL_;
    logic [1:0]  PREV_CMD_SIZE_;
    logic        JMP_FL_;
    logic [31:0] NEW_EXEC_ADDR_OFFSET_;
    logic        HALT_FL_;
    logic        ERR_FL_;
    logic [2:0]  DBG_REG_IDX_;
    logic [31:0] DBG_REG_VAL_;

    int n_cmp = 0;
    int n_mis = 0;

    cmd_executor #(
        .WORD_SIZE_(32),
        .ADDR_SIZE_(32),
        .REG_NUM_  (8)
    ) dut (
        .CLK_                 (CLK_),
        .RST_N_               (RST_N_),
        .CMD_ARGS_            (CMD_ARGS_),
        .EXEC_FL_             (EXEC_FL_),
        .READY_FL_            (READY_FL_),
        .PREV_CMD_SIZE_       (PREV_CMD_SIZE_),
        .JMP_FL_              (JMP_FL_),
        .NEW_EXEC_ADDR_OFFSET_(NEW_EXEC_ADDR_OFFSET_),
        .HALT_FL_             (HALT_FL_),
        .ERR_FL_              (ERR_FL_),
        .DBG_REG_IDX_         (DBG_REG_IDX_),
        .DBG_REG_VAL_         (DBG_REG_VAL_)
    );

    initial begin
        CLK_ = 1'b0;
        forever #5 CLK_ = ~CLK_;
    end

    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [7:0]  lat;
        logic [1:0]  size;
        logic        jmp;
        logic [31:0] off;
        logic [2:0]  ridx;
        logic [31:0] rval;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        enc = {13'd0, rs2, 1'b0, rs1, 1'b0, rd, op};
    endfunction

    function automatic vec_t mkv(input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic [7:0] lat,
                                 input logic [1:0] size, input logic jmp,
                                 input logic [31:0] off, input logic [2:0] ridx,
                                 input logic [31:0] rval);
        mkv = '{w0: w0, w1: w1, w2: w2, lat: lat, size: size, jmp: jmp,
                off: off, ridx: ridx, rval: rval};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [31:0] val);
        DBG_REG_IDX_ = idx;
        #1;
        val = DBG_REG_VAL_;
    endtask

    // Present one command and wait (bounded) for READY; lat=0 if READY never rose
    task automatic run_cmd(input logic [95:0] args, input bit hold, input int bound,
                           output int lat, output logic [1:0] size, output logic jmp,
                           output logic [31:0] off, output logic pulse_fell);
        CMD_ARGS_  = args;
        EXEC_FL_   = 1'b1;
        lat        = 0;
        size       = 'x;
        jmp        = 1'bx;
        off        = 'x;
        pulse_fell = 1'b0;
        for (int i = 1; i <= bound; i++) begin
            @(posedge CLK_);
            #1;
            if (!hold) EXEC_FL_ = 1'b0;
            if (READY_FL_) begin
                lat = i;
                break;
            end
        end
        EXEC_FL_ = 1'b0;
        if (lat != 0) begin
            size = PREV_CMD_SIZE_;
            jmp  = JMP_FL_;
            off  = NEW_EXEC_ADDR_OFFSET_;
            @(posedge CLK_);
            #1;
            pulse_fell = !READY_FL_;
        end
    endtask

    task automatic do_reset();
        RST_N_   = 1'b0;
        EXEC_FL_ = 1'b0;
        @(posedge CLK_);
        #1;
        @(posedge CLK_);
        #1;
        RST_N_ = 1'b1;
    endtask

    int          lat;
    logic [1:0]  sz;
    logic        jf;
    logic [31:0] of;
    logic        fell;
    logic [31:0] rv;
    int          n_ready;

    initial begin
        RST_N_       = 1'b0;
        EXEC_FL_     = 1'b0;
        CMD_ARGS_    = '0;
        DBG_REG_IDX_ = '0;

        vecs[0]  = mkv(enc(OP_LDI, 3'd1, 3'd0, 3'd0), 32'd5, 32'd0, 8'd1, 2'd2, 1'b0, 32'd0, 3'd1, 32'd5);
        vecs[1]  = mkv(enc(OP_LDI, 3'd1, 3'd0, 3'd0), 32'd7, 32'd0, 8'd1, 2'd2, 1'b0, 32'd0, 3'd1, 32'd7);
        vecs[2]  = mkv(enc(OP_LDI, 3'd2, 3'd0, 3'd0), 32'd9, 32'd0, 8'd1, 2'd2, 1'b0, 32'd0, 3'd2, 32'd9);
        vecs[3]  = mkv(enc(OP_ADD, 3'd3, 3'd1, 3'd2), 32'd0, 32'd0, 8'd1, 2'd1, 1'b0, 32'd0, 3'd3, 32'd16);
        vecs[4]  = mkv(enc(OP_SUB, 3'd4, 3'd1, 3'd2), 32'd0, 32'd0, 8'd1, 2'd1, 1'b0, 32'd0, 3'd4, 32'hFFFF_FFFE);
        vecs[5]  = mkv(enc(OP_JZ,  3'd0, 3'd0, 3'd0), 32'hFFFF_FFFC, 32'd0, 8'd1, 2'd2, 1'b1, 32'hFFFF_FFFC, 3'd0, 32'd0);
        vecs[6]  = mkv(enc(OP_LDI, 3'd0, 3'd0, 3'd0), 32'd1, 32'd0, 8'd1, 2'd2, 1'b0, 32'd0, 3'd0, 32'd1);
        vecs[7]  = mkv(enc(OP_JZ,  3'd0, 3'd0, 3'd0), 32'hFFFF_FFFC, 32'd0, 8'd1, 2'd2, 1'b0, 32'd0, 3'd0, 32'd1);
        vecs[8]  = mkv(enc(OP_LDI, 3'd2, 3'd0, 3'd0), 32'd7, 32'd0, 8'd1, 2'd2, 1'b0, 32'd0, 3'd2, 32'd7);
        vecs[9]  = mkv(enc(OP_CMPJ, 3'd0, 3'd1, 3'd2), 32'd8, 32'd12, 8'd1, 2'd3, 1'b1, 32'd8, 3'd1, 32'd7);
        vecs[10] = mkv(enc(OP_LDI, 3'd2, 3'd0, 3'd0), 32'd9, 32'd0, 8'd1, 2'd2, 1'b0, 32'd0, 3'd2, 32'd9);
        vecs[11] = mkv(enc(OP_CMPJ, 3'd0, 3'd1, 3'd2), 32'd8, 32'd12, 8'd1, 2'd3, 1'b1, 32'd12, 3'd2, 32'd9);
        vecs[12] = mkv(enc(OP_JMP, 3'd0, 3'd0, 3'd0), 32'h10, 32'd0, 8'd1, 2'd2, 1'b1, 32'h10, 3'd3, 32'd16);
        vecs[13] = mkv(enc(OP_NOP, 3'd0, 3'd0, 3'd0), 32'd0, 32'd0, 8'd1, 2'd1, 1'b0, 32'd0, 3'd3, 32'd16);
        vecs[14] = mkv(enc(OP_LDI, 3'd1, 3'd0, 3'd0), 32'h0001_0000, 32'd0, 8'd1, 2'd2, 1'b0, 32'd0, 3'd1, 32'h0001_0000);
        vecs[15] = mkv(enc(OP_LDI, 3'd2, 3'd0, 3'd0), 32'h0001_0001, 32'd0, 8'd1, 2'd2, 1'b0, 32'd0, 3'd2, 32'h0001_0001);
        vecs[16] = mkv(enc(OP_MUL, 3'd5, 3'd1, 3'd2), 32'd0, 32'd0, 8'd33, 2'd1, 1'b0, 32'd0, 3'd5, 32'h0001_0000);
        vecs[17] = mkv(enc(OP_MUL, 3'd6, 3'd4, 3'd4), 32'd0, 32'd0, 8'd33, 2'd1, 1'b0, 32'd0, 3'd6, 32'd4);
        vecs[18] = mkv(enc(OP_ADD, 3'd7, 3'd5, 3'd6), 32'd0, 32'd0, 8'd1, 2'd1, 1'b0, 32'd0, 3'd7, 32'h0001_0004);

        do_reset();

        // Reset state
        check("rst_ready", 32'(READY_FL_), 32'd0);
        check("rst_size",  32'(PREV_CMD_SIZE_), 32'd0);
        check("rst_jmp",   32'(JMP_FL_), 32'd0);
        check("rst_off",   NEW_EXEC_ADDR_OFFSET_, 32'd0);
        check("rst_halt",  32'(HALT_FL_), 32'd0);
        check("rst_err",   32'(ERR_FL_), 32'd0);
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), rv);
            check($sformatf("rst_r%0d", r), rv, 32'd0);
        end

        // Table of single commands
        for (int i = 0; i < NV; i++) begin
            run_cmd({vecs[i].w2, vecs[i].w1, vecs[i].w0}, 1'b1, 60, lat, sz, jf, of, fell);
            check($sformatf("v%0d_lat", i),   32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_size", i),  32'(sz), 32'(vecs[i].size));
            check($sformatf("v%0d_jmp", i),   32'(jf), 32'(vecs[i].jmp));
            check($sformatf("v%0d_off", i),   of, vecs[i].off);
            check($sformatf("v%0d_pulse", i), 32'(fell), 32'd1);
            read_reg(vecs[i].ridx, rv);
            check($sformatf("v%0d_reg", i),   rv, vecs[i].rval);
        end

        // EXEC dropped after the first MUL cycle: command still completes
        run_cmd({64'd0, enc(OP_LDI, 3'd1, 3'd0, 3'd0)}, 1'b1, 60, lat, sz, jf, of, fell);
        run_cmd({32'd0, 32'd5, enc(OP_LDI, 3'd2, 3'd0, 3'd0)}, 1'b1, 60, lat, sz, jf, of, fell);
        CMD_ARGS_ = {64'd0, enc(OP_LDI, 3'd1, 3'd0, 3'd0)};
        run_cmd({32'd0, 32'd3, enc(OP_LDI, 3'd1, 3'd0, 3'd0)}, 1'b1, 60, lat, sz, jf, of, fell);
        run_cmd({64'd0, enc(OP_MUL, 3'd3, 3'd1, 3'd2)}, 1'b0, 60, lat, sz, jf, of, fell);
        check("muldrop_lat",  32'(lat), 32'd33);
        check("muldrop_size", 32'(sz), 32'd1);
        read_reg(3'd3, rv);
        check("muldrop_r3", rv, 32'd15);

        // Reset in the middle of a MUL: rd must not be written
        run_cmd({64'd0, enc(OP_MUL, 3'd5, 3'd1, 3'd2)}, 1'b1, 10, lat, sz, jf, of, fell);
        check("midmul_noready", 32'(lat), 32'd0);
        RST_N_ = 1'b0;
        @(posedge CLK_);
        #1;
        RST_N_ = 1'b1;
        check("midmul_ready", 32'(READY_FL_), 32'd0);
        check("midmul_size",  32'(PREV_CMD_SIZE_), 32'd0);
        check("midmul_jmp",   32'(JMP_FL_), 32'd0);
        check("midmul_off",   NEW_EXEC_ADDR_OFFSET_, 32'd0);
        read_reg(3'd1, rv);
        check("midmul_r1", rv, 32'd0);
        read_reg(3'd5, rv);
        check("midmul_r5", rv, 32'd0);
        n_ready = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK_);
            #1;
            if (READY_FL_) n_ready++;
        end
        check("midmul_quiet", 32'(n_ready), 32'd0);
        read_reg(3'd5, rv);
        check("midmul_r5_late", rv, 32'd0);
        run_cmd({32'd0, 32'd5, enc(OP_LDI, 3'd1, 3'd0, 3'd0)}, 1'b1, 60, lat, sz, jf, of, fell);
        check("postrst_lat", 32'(lat), 32'd1);
        read_reg(3'd1, rv);
        check("postrst_r1", rv, 32'd5);

        // Reset while in ACK
        CMD_ARGS_ = {32'd0, 32'd6, enc(OP_LDI, 3'd2, 3'd0, 3'd0)};
        EXEC_FL_  = 1'b1;
        @(posedge CLK_);
        #1;
        check("ack_ready", 32'(READY_FL_), 32'd1);
        RST_N_   = 1'b0;
        EXEC_FL_ = 1'b0;
        @(posedge CLK_);
        #1;
        RST_N_ = 1'b1;
        check("ackrst_ready", 32'(READY_FL_), 32'd0);
        check("ackrst_size",  32'(PREV_CMD_SIZE_), 32'd0);
        read_reg(3'd2, rv);
        check("ackrst_r2", rv, 32'd0);

        // Illegal opcode: sticky error and halt, no further retires
        run_cmd({64'd0, 32'h0000_0042}, 1'b1, 10, lat, sz, jf, of, fell);
        check("ill_noready", 32'(lat), 32'd0);
        check("ill_err",  32'(ERR_FL_), 32'd1);
        check("ill_halt", 32'(HALT_FL_), 32'd1);
        run_cmd({32'd0, 32'd9, enc(OP_LDI, 3'd1, 3'd0, 3'd0)}, 1'b1, 20, lat, sz, jf, of, fell);
        check("ill_absorb", 32'(lat), 32'd0);
        read_reg(3'd1, rv);
        check("ill_r1", rv, 32'd0);
        check("ill_err_hold", 32'(ERR_FL_), 32'd1);

        // HLT: halt without error
        do_reset();
        check("hltrst_err",  32'(ERR_FL_), 32'd0);
        check("hltrst_halt", 32'(HALT_FL_), 32'd0);
        run_cmd({64'd0, enc(OP_HLT, 3'd0, 3'd0, 3'd0)}, 1'b1, 10, lat, sz, jf, of, fell);
        check("hlt_noready", 32'(lat), 32'd0);
        check("hlt_halt", 32'(HALT_FL_), 32'd1);
        check("hlt_err",  32'(ERR_FL_), 32'd0);
        run_cmd({32'd0, 32'd4, enc(OP_LDI, 3'd3, 3'd0, 3'd0)}, 1'b1, 10, lat, sz, jf, of, fell);
        check("hlt_absorb", 32'(lat), 32'd0);
        read_reg(3'd3, rv);
        check("hlt_r3", rv, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
